// File: rtl/uart_line_echo_if.sv
// Bus between the line-echo engine (master) and the UART register slave.
// One request at a time; bus_ready is a single-cycle completion strobe.
interface uart_line_echo_if;
    logic        bus_enable;
    logic        bus_wr_en;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_enable,
        output bus_wr_en,
        output bus_addr,
        output bus_wdata,
        input  bus_ready,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_enable,
        input  bus_wr_en,
        input  bus_addr,
        input  bus_wdata,
        output bus_ready,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/uart_line_echo.sv
// Programs a UART, buffers received bytes into lines and replays each line back out.
// Optional macro UART_LINE_ECHO_UPCASE_EN upcases replayed ASCII letters.
module uart_line_echo #(
    parameter logic [15:0] BAUD_DIV    = 16'd469,
    parameter int unsigned DEPTH       = 16,
    parameter logic [7:0]  TERM        = 8'h0D,
    parameter logic [31:0] ADDR_DATA     = 32'd0,
    parameter logic [31:0] ADDR_STATUS   = 32'd1,
    parameter logic [31:0] ADDR_INT      = 32'd2,
    parameter logic [31:0] ADDR_INT_PEND = 32'd3,
    parameter logic [31:0] ADDR_BAUD_L   = 32'd4,
    parameter logic [31:0] ADDR_BAUD_H   = 32'd5
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_line_echo_if.master        bus,
    output logic                    busy,
    output logic [15:0]             line_count,
    output logic                    err_sticky
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [3:0] {
        StInitBl,
        StInitBh,
        StInitIe,
        StPoll,
        StReadRx,
        StStore,
        StTxPoll,
        StTxWrite,
        StClrInt
    } state_e;

    state_e            r_state;
    logic              r_bus_enable;
    logic              r_bus_wr_en;
    logic [31:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic [CntW-1:0]   r_tx_cnt;
    logic [7:0]        r_rx_byte;
    logic [15:0]       r_line_count;
    logic              r_err_sticky;
    logic [7:0]        r_buf [DEPTH];

    state_e            w_state_d;
    logic              w_en_d;
    logic              w_wr_d;
    logic [31:0]       w_addr_d;
    logic [31:0]       w_wdata_d;
    logic [PtrW-1:0]   w_wr_ptr_d;
    logic [PtrW-1:0]   w_rd_ptr_d;
    logic [CntW-1:0]   w_count_d;
    logic [CntW-1:0]   w_count_inc;
    logic [CntW-1:0]   w_tx_cnt_d;
    logic [CntW-1:0]   w_tx_cnt_inc;
    logic [7:0]        w_rx_byte_d;
    logic [15:0]       w_line_d;
    logic              w_err_d;
    logic              w_buf_we;
    logic              w_xact;
    logic              w_xfer_done;
    logic              w_req_wr;
    logic [31:0]       w_req_addr;
    logic [31:0]       w_req_data;
    logic [7:0]        w_tx_raw;
    logic [7:0]        w_tx_byte;
    logic              w_unused_rdata;

    assign w_xfer_done    = r_bus_enable & bus.bus_ready;
    assign w_count_inc    = r_count + 1'b1;
    assign w_tx_cnt_inc   = r_tx_cnt + 1'b1;
    assign w_tx_raw       = r_buf[r_rd_ptr];
    assign w_unused_rdata = ^bus.bus_rdata[31:8];

`ifdef UART_LINE_ECHO_UPCASE_EN
    assign w_tx_byte = ((w_tx_raw >= 8'h61) && (w_tx_raw <= 8'h7A)) ? (w_tx_raw - 8'h20)
                                                                      : w_tx_raw;
`else
    assign w_tx_byte = w_tx_raw;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_en_d      = r_bus_enable;
        w_wr_d      = r_bus_wr_en;
        w_addr_d    = r_bus_addr;
        w_wdata_d   = r_bus_wdata;
        w_wr_ptr_d  = r_wr_ptr;
        w_rd_ptr_d  = r_rd_ptr;
        w_count_d   = r_count;
        w_tx_cnt_d  = r_tx_cnt;
        w_rx_byte_d = r_rx_byte;
        w_line_d    = r_line_count;
        w_err_d     = r_err_sticky | (w_xfer_done & bus.bus_err);
        w_buf_we    = 1'b0;
        w_xact      = 1'b1;
        w_req_wr    = 1'b0;
        w_req_addr  = ADDR_STATUS;
        w_req_data  = 32'd0;

        // Request each bus state would issue; STORE is purely internal.
        case (r_state)
            StInitBl: begin
                w_req_wr   = 1'b1;
                w_req_addr = ADDR_BAUD_L;
                w_req_data = {24'd0, BAUD_DIV[7:0]};
            end
            StInitBh: begin
                w_req_wr   = 1'b1;
                w_req_addr = ADDR_BAUD_H;
                w_req_data = {24'd0, BAUD_DIV[15:8]};
            end
            StInitIe: begin
                w_req_wr   = 1'b1;
                w_req_addr = ADDR_INT;
                w_req_data = 32'd3;
            end
            StPoll, StTxPoll: begin
                w_req_addr = ADDR_STATUS;
            end
            StReadRx: begin
                w_req_addr = ADDR_DATA;
            end
            StTxWrite: begin
                w_req_wr   = 1'b1;
                w_req_addr = ADDR_DATA;
                w_req_data = {24'd0, w_tx_byte};
            end
            StClrInt: begin
                w_req_wr   = 1'b1;
                w_req_addr = ADDR_INT_PEND;
                w_req_data = 32'd3;
            end
            default: w_xact = 1'b0;
        endcase

        // Enable only rises from low, so there is always an idle cycle between requests.
        if (w_xact && !r_bus_enable) begin
            w_en_d    = 1'b1;
            w_wr_d    = w_req_wr;
            w_addr_d  = w_req_addr;
            w_wdata_d = w_req_data;
        end
        if (w_xfer_done) begin
            w_en_d = 1'b0;
            w_wr_d = 1'b0;
        end

        case (r_state)
            StInitBl: if (w_xfer_done) w_state_d = StInitBh;
            StInitBh: if (w_xfer_done) w_state_d = StInitIe;
            StInitIe: if (w_xfer_done) w_state_d = StPoll;
            StPoll: begin
                if (w_xfer_done && bus.bus_rdata[0]) w_state_d = StReadRx;
            end
            StReadRx: begin
                if (w_xfer_done) begin
                    w_rx_byte_d = bus.bus_rdata[7:0];
                    w_state_d   = StStore;
                end
            end
            StStore: begin
                w_buf_we   = 1'b1;
                w_wr_ptr_d = r_wr_ptr + 1'b1;
                w_count_d  = w_count_inc;
                if ((r_rx_byte == TERM) || (w_count_inc == CntW'(DEPTH))) begin
                    w_tx_cnt_d = '0;
                    w_state_d  = StTxPoll;
                    if (r_rx_byte != TERM) w_err_d = 1'b1;
                end else begin
                    w_state_d = StPoll;
                end
            end
            StTxPoll: begin
                if (w_xfer_done && !bus.bus_rdata[1]) w_state_d = StTxWrite;
            end
            StTxWrite: begin
                if (w_xfer_done) begin
                    w_rd_ptr_d = r_rd_ptr + 1'b1;
                    w_tx_cnt_d = w_tx_cnt_inc;
                    w_state_d  = (w_tx_cnt_inc == r_count) ? StClrInt : StTxPoll;
                end
            end
            StClrInt: begin
                if (w_xfer_done) begin
                    w_count_d  = '0;
                    w_tx_cnt_d = '0;
                    w_wr_ptr_d = '0;
                    w_rd_ptr_d = '0;
                    w_line_d   = r_line_count + 16'd1;
                    w_state_d  = StPoll;
                end
            end
            default: w_state_d = StInitBl;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StInitBl;
            r_bus_enable <= 1'b0;
            r_bus_wr_en  <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_tx_cnt     <= '0;
            r_rx_byte    <= 8'd0;
            r_line_count <= 16'd0;
            r_err_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bus_enable <= w_en_d;
            r_bus_wr_en  <= w_wr_d;
            r_bus_addr   <= w_addr_d;
            r_bus_wdata  <= w_wdata_d;
            r_wr_ptr     <= w_wr_ptr_d;
            r_rd_ptr     <= w_rd_ptr_d;
            r_count      <= w_count_d;
            r_tx_cnt     <= w_tx_cnt_d;
            r_rx_byte    <= w_rx_byte_d;
            r_line_count <= w_line_d;
            r_err_sticky <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) r_buf[r_wr_ptr] <= r_rx_byte;
    end

    assign bus.bus_enable = r_bus_enable;
    assign bus.bus_wr_en  = r_bus_wr_en;
    assign bus.bus_addr   = r_bus_addr;
    assign bus.bus_wdata  = r_bus_wdata;
    assign busy           = (r_state != StPoll);
    assign line_count     = r_line_count;
    assign err_sticky     = r_err_sticky;

endmodule

// File: tb/tb_uart_line_echo.sv
// Bench for uart_line_echo: UART slave model plus a line-splitting reference model.
module tb_uart_line_echo;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] BAUD  = 16'd469;
    localparam logic [7:0]  TERM  = 8'h0D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] line_count;
    logic        err_sticky;

    uart_line_echo_if bus_if ();

    uart_line_echo #(
        .BAUD_DIV (BAUD),
        .DEPTH    (DEPTH),
        .TERM     (TERM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .busy       (busy),
        .line_count (line_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    xact_t       xact_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  line_buf[$];
    int          exp_lines;
    int          int_pend_cnt;
    logic [31:0] int_pend_data;
    bit          exp_err;
    int          lat_min = 2;
    int          lat_max = 2;
    int          lat_cur;
    int          wait_cnt;
    int          busy_cfg;
    int          busy_left;
    int          status_reads;
    int          err_at;
    int          rx_line_cnt;
    bit          replaying;
    int          violations;
    int          total;
    int          bad;

    function automatic logic [7:0] upc(input logic [7:0] b);
`ifdef UART_LINE_ECHO_UPCASE_EN
        return ((b >= 8'h61) && (b <= 8'h7A)) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // UART register slave: services one request per completion strobe.
    task automatic service();
        logic [31:0] a;
        logic [7:0]  b;
        a = bus_if.bus_addr;
        xact_q.push_back('{bus_if.bus_wr_en, a, bus_if.bus_wdata});
        bus_if.bus_rdata = 32'd0;
        bus_if.bus_err   = 1'b0;
        if (!bus_if.bus_wr_en && a == 32'd1) begin
            status_reads++;
            bus_if.bus_rdata = {30'd0, busy_left > 0, rx_q.size() > 0};
            if (busy_left > 0) busy_left--;
            if (status_reads == err_at) begin
                bus_if.bus_err = 1'b1;
                exp_err = 1'b1;
            end
        end else if (!bus_if.bus_wr_en && a == 32'd0) begin
            if (replaying) violations++;
            b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            bus_if.bus_rdata = {24'd0, b};
            rx_line_cnt++;
            if (b == TERM || rx_line_cnt == DEPTH) begin
                replaying   = 1'b1;
                rx_line_cnt = 0;
            end
        end else if (bus_if.bus_wr_en && a == 32'd0) begin
            if (busy_left > 0) violations++;
            tx_q.push_back(bus_if.bus_wdata[7:0]);
            busy_left = busy_cfg;
        end else if (bus_if.bus_wr_en && a == 32'd3) begin
            int_pend_cnt++;
            int_pend_data = bus_if.bus_wdata;
            replaying = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus_if.bus_ready = 1'b0;
            bus_if.bus_err   = 1'b0;
            wait_cnt = 0;
        end else if (bus_if.bus_ready) begin
            bus_if.bus_ready = 1'b0;
            bus_if.bus_err   = 1'b0;
        end else if (bus_if.bus_enable) begin
            if (wait_cnt == 0) lat_cur = $urandom_range(lat_max, lat_min);
            wait_cnt++;
            if (wait_cnt >= lat_cur) begin
                wait_cnt = 0;
                service();
                bus_if.bus_ready = 1'b1;
            end
        end
    end

    // Reference: a line closes on TERM or when DEPTH bytes are held; overflow flags an error.
    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        line_buf.push_back(b);
        if (b == TERM || line_buf.size() == DEPTH) begin
            if (b != TERM) exp_err = 1'b1;
            foreach (line_buf[i]) exp_tx.push_back(upc(line_buf[i]));
            exp_lines++;
            line_buf.delete();
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) feed(s[i]);
    endtask

    task automatic clear_model();
        xact_q.delete();
        tx_q.delete();
        rx_q.delete();
        exp_tx.delete();
        line_buf.delete();
        exp_lines    = 0;
        int_pend_cnt = 0;
        status_reads = 0;
        rx_line_cnt  = 0;
        replaying    = 1'b0;
        busy_left    = 0;
        exp_err      = 1'b0;
        err_at       = 0;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (xact_q.size() < n && k < 2000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("wait_log", k < 2000, 1);
    endtask

    task automatic wait_lines(input int n);
        int k = 0;
        while (!(int_pend_cnt >= n && rx_q.size() == 0 && !busy) && k < 4000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("wait_lines", k < 4000, 1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic cmp_tx(input string tag);
        chk({tag, "_len"}, tx_q.size(), exp_tx.size());
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) chk({tag, "_byte"}, tx_q[i], exp_tx[i]);
    endtask

    task automatic chk_init(input string tag);
        wait_log(4);
        chk({tag, "_bl_a"}, xact_q[0].addr, 32'd4);
        chk({tag, "_bl_d"}, xact_q[0].data, {24'd0, BAUD[7:0]});
        chk({tag, "_bh_a"}, xact_q[1].addr, 32'd5);
        chk({tag, "_bh_d"}, xact_q[1].data, {24'd0, BAUD[15:8]});
        chk({tag, "_ie_a"}, xact_q[2].addr, 32'd2);
        chk({tag, "_ie_d"}, xact_q[2].data, 32'd3);
        chk({tag, "_wr"}, {xact_q[0].wr, xact_q[1].wr, xact_q[2].wr, xact_q[3].wr}, 4'b1110);
        chk({tag, "_poll"}, xact_q[3].addr, 32'd1);
    endtask

    initial begin
        int k;
        int n;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'd0;
        bus_if.bus_err   = 1'b0;
        busy_cfg = 0;
        violations = 0;
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_en", bus_if.bus_enable, 0);
        chk("rst_wr", bus_if.bus_wr_en, 0);
        chk("rst_addr", bus_if.bus_addr, 0);
        chk("rst_wdata", bus_if.bus_wdata, 0);
        chk("rst_busy", busy, 1);
        chk("rst_lines", line_count, 0);
        chk("rst_err", err_sticky, 0);
        rst = 1'b0;

        chk_init("init");

        send_str("ab");
        feed(TERM);
        wait_lines(1);
        cmp_tx("ab");
        chk("ab_lines", line_count, exp_lines);
        chk("ab_pend", int_pend_data, 32'd3);
        chk("ab_err", err_sticky, exp_err);

        busy_cfg = 5;
        send_str("cd");
        feed(TERM);
        wait_lines(2);
        cmp_tx("txbusy");
        chk("txbusy_lines", line_count, exp_lines);
        busy_cfg = 0;

        send_str("wxyzq");
        wait_lines(3);
        cmp_tx("ovf");
        chk("ovf_err", err_sticky, 1);
        chk("ovf_lines", line_count, exp_lines);
        feed(TERM);
        wait_lines(4);
        cmp_tx("ovf_q");

        rst = 1'b1;
        @(posedge clk); #2;
        clear_model();
        err_at = 2;
        rst = 1'b0;
        chk_init("errinit");
        k = 0;
        while (status_reads < 3 && k < 2000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("err_wait", k < 2000, 1);
        chk("err_sticky", err_sticky, 1);
        chk("err_seq", {xact_q[5].wr, xact_q[5].addr}, {1'b0, 32'd1});
        send_str("ok");
        feed(TERM);
        wait_lines(1);
        cmp_tx("err_ok");
        chk("err_lines", line_count, exp_lines);

        lat_min  = 1;
        lat_max  = 3;
        busy_cfg = $urandom_range(3, 0);
        err_at   = status_reads + $urandom_range(40, 5);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7, 0) == 0) feed(TERM);
            else feed(8'h58 + 8'($urandom_range(39, 0)));
        end
        feed(TERM);
        n = exp_lines;
        wait_lines(n);
        cmp_tx("rnd");
        chk("rnd_lines", line_count, exp_lines);
        chk("rnd_err", err_sticky, exp_err);

        lat_min  = 3;
        lat_max  = 3;
        busy_cfg = 0;
        send_str("hi");
        feed(TERM);
        k = 0;
        while (!(bus_if.bus_enable && bus_if.bus_wr_en && bus_if.bus_addr == 32'd0) && k < 2000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("txw_wait", k < 2000, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("midrst_en", bus_if.bus_enable, 0);
        chk("midrst_busy", busy, 1);
        chk("midrst_lines", line_count, 0);
        clear_model();
        rst = 1'b0;
        chk_init("reinit");
        chk("reinit_err", err_sticky, 0);
        chk("reinit_lines", line_count, 0);
        chk("violations", violations, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
